// File: rtl/sys_defs_pkg.sv
// Shared pipeline types for the decode/rename -> reservation-station path.
// `DQ_SZ supplies the default dispatch queue depth.
`ifndef DQ_SZ
`define DQ_SZ 4
`endif

package sys_defs;

  localparam int PRF_IDX_W = 6;

  typedef struct packed {
    logic [PRF_IDX_W-1:0] idx;
    logic                 ready;
  } TAG;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  op;
    TAG          dest;
    TAG          t1;
    TAG          t2;
  } ID_IS_PACKET;

  // The zero register is architecturally always ready, so it never wakes up.
  function automatic logic tag_hit(input TAG src, input TAG bcast);
    return bcast.ready && (bcast.idx != '0) && (src.idx == bcast.idx);
  endfunction

endpackage

// File: rtl/dq_wakeup.sv
// Combinational CDB snoop: sets the ready bit of any source tag that matches
// the current broadcast. The destination tag passes through unchanged.
module dq_wakeup
  import sys_defs::*;
(
  input  ID_IS_PACKET i_packet,
  input  TAG          i_cdb,
  output ID_IS_PACKET o_packet
);

  always_comb begin
    o_packet = i_packet;
    if (tag_hit(i_packet.t1, i_cdb)) o_packet.t1.ready = 1'b1;
    if (tag_hit(i_packet.t2, i_cdb)) o_packet.t2.ready = 1'b1;
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO between rename and the reservation station, with CDB
// snooping on every held packet. Define DQ_BYPASS_EN for the empty-queue bypass.
`ifndef DQ_SZ
`define DQ_SZ 4
`endif

module dispatch_queue
  import sys_defs::*;
#(
  parameter int DQ_DEPTH = `DQ_SZ,
  parameter int DQ_PTR_W = $clog2(DQ_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  TAG                cdb,
  input  ID_IS_PACKET       enq_packet,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic              rs_free,
  output ID_IS_PACKET       is_packet_out,
  output logic              rs_in_en,
  input  logic              squash,
  output logic [DQ_PTR_W:0] count
);

  localparam logic [DQ_PTR_W:0] LP_FULL = (DQ_PTR_W + 1)'(DQ_DEPTH);

  ID_IS_PACKET         r_slot [DQ_DEPTH];
  logic                r_valid [DQ_DEPTH];
  logic [DQ_PTR_W-1:0] r_head;
  logic [DQ_PTR_W-1:0] r_tail;
  logic [DQ_PTR_W:0]   r_count;

  ID_IS_PACKET w_slot_fwd [DQ_DEPTH];
  ID_IS_PACKET w_enq_fwd;
  ID_IS_PACKET w_head_fwd;
  logic        w_empty;
  logic        w_full;
  logic        w_bypass;
  logic        w_enq_fire;
  logic        w_deq_fire;

  genvar gi;
  generate
    for (gi = 0; gi < DQ_DEPTH; gi++) begin : g_slot
      dq_wakeup u_slot_wk (
        .i_packet (r_slot[gi]),
        .i_cdb    (cdb),
        .o_packet (w_slot_fwd[gi])
      );

      // Held packets re-latch their forwarded copy so a broadcast is never lost.
      always_ff @(posedge clock) begin
        if (w_enq_fire && (r_tail == DQ_PTR_W'(gi))) begin
          r_slot[gi] <= w_enq_fwd;
        end else if (r_valid[gi]) begin
          r_slot[gi] <= w_slot_fwd[gi];
        end
      end

      always_ff @(posedge clock) begin
        if (!reset || squash) begin
          r_valid[gi] <= 1'b0;
        end else if (w_enq_fire && (r_tail == DQ_PTR_W'(gi))) begin
          r_valid[gi] <= 1'b1;
        end else if (w_deq_fire && (r_head == DQ_PTR_W'(gi))) begin
          r_valid[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  dq_wakeup u_enq_wk (
    .i_packet (enq_packet),
    .i_cdb    (cdb),
    .o_packet (w_enq_fwd)
  );

  dq_wakeup u_head_wk (
    .i_packet (r_slot[r_head]),
    .i_cdb    (cdb),
    .o_packet (w_head_fwd)
  );

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_FULL);

`ifdef DQ_BYPASS_EN
  assign w_bypass = w_empty && enq_valid && rs_free && !squash;
`else
  assign w_bypass = 1'b0;
`endif

  // Admission looks only at registered occupancy, never at a same-cycle dequeue.
  assign enq_ready  = !w_full && !squash;
  assign w_enq_fire = enq_valid && enq_ready && !w_bypass;
  assign w_deq_fire = !w_empty && rs_free && !squash;
  assign rs_in_en   = w_deq_fire || w_bypass;
  assign count      = r_count;

  always_comb begin
    is_packet_out = '0;
    if (w_bypass) begin
      is_packet_out = w_enq_fwd;
    end else if (!w_empty) begin
      is_packet_out = w_head_fwd;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_fire) r_tail <= r_tail + 1'b1;
      if (w_deq_fire) r_head <= r_head + 1'b1;
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue with a scoreboard queue of expected packets
// and a reference CDB-snoop model; honours DQ_BYPASS_EN like the design.
module tb_dispatch_queue;
  import sys_defs::*;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  TAG          cdb;
  ID_IS_PACKET enq_packet;
  logic        enq_valid;
  logic        enq_ready;
  logic        rs_free;
  ID_IS_PACKET is_packet_out;
  logic        rs_in_en;
  logic        squash;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;
  ID_IS_PACKET sb_q[$];

  dispatch_queue #(.DQ_DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .cdb           (cdb),
    .enq_packet    (enq_packet),
    .enq_valid     (enq_valid),
    .enq_ready     (enq_ready),
    .rs_free       (rs_free),
    .is_packet_out (is_packet_out),
    .rs_in_en      (rs_in_en),
    .squash        (squash),
    .count         (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic ID_IS_PACKET ref_fwd(input ID_IS_PACKET p, input TAG b);
    ID_IS_PACKET r;
    r = p;
    if (b.ready && b.idx != 6'd0) begin
      if (p.t1.idx == b.idx) r.t1.ready = 1'b1;
      if (p.t2.idx == b.idx) r.t2.ready = 1'b1;
    end
    return r;
  endfunction

  function automatic ID_IS_PACKET mk(input int d, input int a, input bit ar,
                                     input int b, input bit br);
    ID_IS_PACKET p;
    p.pc         = 32'h1000 + 32'(d) * 32'd4;
    p.op         = 5'(d);
    p.dest.idx   = 6'(d);
    p.dest.ready = 1'b0;
    p.t1.idx     = 6'(a);
    p.t1.ready   = ar;
    p.t2.idx     = 6'(b);
    p.t2.ready   = br;
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // return 1 time unit after the rising edge so the caller drives the next cycle.
  task automatic step();
    ID_IS_PACKET enq_f, exp_pkt;
    logic exp_ready, exp_en, byp, do_enq, do_deq;
    @(negedge clock);
    foreach (sb_q[i]) sb_q[i] = ref_fwd(sb_q[i], cdb);
    enq_f = ref_fwd(enq_packet, cdb);
    byp = 1'b0;
`ifdef DQ_BYPASS_EN
    byp = (sb_q.size() == 0) && enq_valid && rs_free && !squash;
`endif
    exp_ready = (sb_q.size() != DEPTH) && !squash;
    exp_en    = ((sb_q.size() != 0) && rs_free && !squash) || byp;
    exp_pkt   = byp ? enq_f : ((sb_q.size() != 0) ? sb_q[0] : '0);
    check("enq_ready", 64'(enq_ready), 64'(exp_ready));
    check("rs_in_en", 64'(rs_in_en), 64'(exp_en));
    check("count", 64'(count), 64'(sb_q.size()));
    check("is_packet_out", 64'(is_packet_out), 64'(exp_pkt));
    do_deq = exp_en && !byp;
    do_enq = enq_valid && exp_ready && !byp;
    if (byp)
      $display("bypass dest=%0d t1=%0d/%0b t2=%0d/%0b", enq_f.dest.idx,
               enq_f.t1.idx, enq_f.t1.ready, enq_f.t2.idx, enq_f.t2.ready);
    if (do_deq)
      $display("dequeue dest=%0d t1=%0d/%0b t2=%0d/%0b", exp_pkt.dest.idx,
               exp_pkt.t1.idx, exp_pkt.t1.ready, exp_pkt.t2.idx, exp_pkt.t2.ready);
    if (do_enq)
      $display("enqueue dest=%0d occupancy_before=%0d", enq_f.dest.idx, sb_q.size());
    if (!reset || squash) begin
      sb_q.delete();
    end else begin
      if (do_deq) void'(sb_q.pop_front());
      if (do_enq) sb_q.push_back(enq_f);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    cdb        = '0;
    enq_packet = '0;
    enq_valid  = 1'b0;
    rs_free    = 1'b0;
    squash     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    step();
    reset = 1'b1;

    // Three packets streamed straight through.
    rs_free = 1'b1;
    for (int d = 5; d <= 7; d++) begin
      enq_valid  = 1'b1;
      enq_packet = mk(d, d + 16, 1'b0, d + 24, 1'b1);
      step();
    end
    enq_valid = 1'b0;
    repeat (2) step();

    // Fill while rs is busy; fifth packet is held back.
    rs_free = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq_valid  = 1'b1;
      enq_packet = mk(8 + i, 1, 1'b1, 2, 1'b0);
      step();
    end
    rs_free = 1'b1;
    step();
    step();
    enq_valid = 1'b0;
    repeat (5) step();

    // Wakeup of a buffered packet, zero-register broadcast, enqueue-path snoop.
    rs_free    = 1'b0;
    enq_valid  = 1'b1;
    enq_packet = mk(20, 12, 1'b0, 0, 1'b0);
    step();
    enq_valid = 1'b0;
    cdb = '{idx: 6'd12, ready: 1'b1};
    step();
    cdb = '{idx: 6'd0, ready: 1'b1};
    step();
    cdb = '{idx: 6'd13, ready: 1'b0};
    enq_valid  = 1'b1;
    enq_packet = mk(21, 13, 1'b0, 14, 1'b0);
    step();
    cdb        = '{idx: 6'd14, ready: 1'b1};
    enq_packet = mk(22, 3, 1'b0, 14, 1'b0);
    step();
    cdb       = '0;
    enq_valid = 1'b0;
    rs_free   = 1'b1;
    repeat (4) step();

    // Squash with three held packets and a pending enqueue.
    rs_free = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enq_valid  = 1'b1;
      enq_packet = mk(24 + i, 4, 1'b0, 5, 1'b0);
      step();
    end
    squash     = 1'b1;
    rs_free    = 1'b1;
    enq_packet = mk(27, 4, 1'b0, 5, 1'b0);
    step();
    squash    = 1'b0;
    enq_valid = 1'b0;
    step();

    // Interleaved traffic across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      enq_valid  = 1'b1;
      enq_packet = mk(32 + i, 6 + i, 1'b0, 40 + i, 1'b1);
      rs_free    = i[0];
      step();
      enq_valid = 1'b0;
      rs_free   = ~i[0];
      step();
    end
    enq_valid = 1'b0;
    rs_free   = 1'b1;
    repeat (5) step();

    // Empty queue with rs free and a valid packet (bypass when enabled).
    enq_valid  = 1'b1;
    rs_free    = 1'b1;
    cdb        = '{idx: 6'd9, ready: 1'b1};
    enq_packet = mk(50, 9, 1'b0, 10, 1'b0);
    step();
    cdb       = '0;
    enq_valid = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- In-order FIFO of ID_IS_PACKETs between decode/rename and the reservation station (rs).
- Absorbs decode bursts and holds packets while rs reports no free entry.
- Snoops the CDB on every buffered packet so no wakeup broadcast is lost while a packet waits.
- Pushes the head packet into rs via in_en when rs asserts free.

Parameters:
- DQ_DEPTH, 4: number of packet slots; power of 2, at least 2.
- DQ_PTR_W, $clog2(DQ_DEPTH): width of the head and tail pointers.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on the clock rising edge.
- cdb  in  TAG  completing physical tag; its ready bit qualifies the broadcast.
- enq_packet  in  ID_IS_PACKET  packet from decode/rename.
- enq_valid  in  1  enq_packet is valid.
- enq_ready  out  1  queue accepts a packet this cycle.
- rs_free  in  1  rs free output; rs has an empty slot.
- is_packet_out  out  ID_IS_PACKET  head packet, CDB-forwarded; drives rs is_packet_in.
- rs_in_en  out  1  drives rs in_en.
- squash  in  1  mispredict flush.
- count  out  DQ_PTR_W+1  current occupancy.

Behaviour:
- One clock; reset is synchronous and active-low.
- While reset is low at a clock edge: head=0, tail=0, count=0, all valid bits 0.
  - Outputs then read enq_ready=1, rs_in_en=0, is_packet_out='0.
- enq_ready = (count != DQ_DEPTH) && !squash.
  - Admission is registered only: a full queue does not accept a packet even if a dequeue happens the same cycle.
- Enqueue fires when enq_valid && enq_ready: slot[tail] <= enq_packet (after CDB snoop), tail++.
- rs_in_en = (count != 0) && rs_free && !squash.
- is_packet_out = slot[head] with same-cycle CDB forwarding applied. It is '0 when count == 0.
- Dequeue fires when rs_in_en: head++ at the edge.
- count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - unchanged when both fire.
- Pointers wrap modulo DQ_DEPTH; full and empty are resolved by count, never by pointer equality.
- Latency: a packet enqueued at edge N is presentable to rs in cycle N+1 at the earliest. There is no pass-through unless the optional feature is on.
- CDB snoop, applied each cycle when cdb.ready=1:
  - For each valid slot, and for enq_packet, if source tag t1 (or t2) index equals cdb index, that source's ready bit is set.
  - Dest tag is untouched.
  - Index 0 (zero register) is never matched.
- Forwarding is also applied combinationally to is_packet_out, so the rs latches the ready bit in the broadcast cycle.
- squash (highest priority after reset):
  - At the edge: head=tail=0, count=0, all valid bits cleared.
  - The enqueue and dequeue of that cycle are suppressed (rs_in_en and enq_ready are forced 0 combinationally).
- Order is strictly FIFO; there is no reordering.

Optional Feature:
- Macro: DQ_BYPASS_EN.
- Defined: when count==0, enq_valid, rs_free and !squash all hold:
  - enq_packet (CDB-forwarded) drives is_packet_out directly and rs_in_en=1;
  - the packet is not written, and the pointers and count do not change (zero-latency path).
- Undefined: no bypass; the minimum latency is 1 cycle as above.

Decomposition:
- Shared sys_defs package: ID_IS_PACKET, TAG, and the DQ_DEPTH default as `DQ_SZ.
- Sub-module dq_wakeup: purely combinational. Takes one ID_IS_PACKET plus cdb and returns the forwarded packet.
  - It is instantiated once per slot, once for the enqueue path and once for the output.

Test Plan:
- Reset low 2 cycles then high, enqueue 3 packets (dest tags 5, 6, 7) with rs_free=1 -> packets appear on is_packet_out in order 5, 6, 7 on consecutive cycles starting 1 cycle after the first enqueue; count returns to 0.
- rs_free=0, enqueue 5 packets with DQ_DEPTH=4 -> enq_ready drops after the 4th, the 5th is held; count=4. Raise rs_free -> 4 dequeues; enq_ready=1 again.
- Buffered packet with t1 idx 12 not ready; cdb={12, ready=1} for one cycle -> t1.ready=1 persists on is_packet_out when later dequeued. A same-cycle check shows the forwarded ready on is_packet_out.
- Full queue, enq_valid=1 and rs_free=1 the same cycle -> dequeue occurs, enqueue refused; count 4 -> 3.
- count=3, assert squash with enq_valid=1 -> rs_in_en=0, enq_ready=0 that cycle; next cycle count=0.
- Wrap-around: 10 enqueue/dequeue pairs interleaved with rs_free toggling -> FIFO order preserved across pointer wrap.
- With DQ_BYPASS_EN defined: empty queue, enq_valid=1, rs_free=1 -> rs_in_en=1 in the same cycle, count stays 0.
